z8_trace_buffer: RTL and testbench

//   On-chip instruction trace capture for the Z8 SoC; a synthesizable successor to bench-only pc/state probes.

---
 rtl/z8_trace_buffer.sv | 173 +++++++++++++++++
 tb/tb_z8_trace_buffer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/z8_trace_buffer.sv
// ============================================================================
// Module   : z8_trace_buffer
// Brief    : Instruction trace capture into a circular RAM. Capture starts on
//            arm, stops POST_TRIG samples after a PC-match trigger, and is read
//            back oldest-first through a registered read port.
// Options  : `define TRACE_FLAGS_EN to store the retire flags with each entry
//            (entry = {flags, pc, instr}); otherwise entry = {pc, instr}.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module z8_trace_buffer #(
    parameter int DEPTH     = 64,
    parameter int PC_W      = 16,
    parameter int POST_TRIG = 16,
    parameter int AW        = $clog2(DEPTH),
`ifdef TRACE_FLAGS_EN
    localparam int EW       = PC_W + 16
`else
    localparam int EW       = PC_W + 8
`endif
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            sample_valid,
    input  logic [PC_W-1:0] sample_pc,
    input  logic [7:0]      sample_instr,
    input  logic [7:0]      sample_flags,
    input  logic            arm,
    input  logic            trig_en,
    input  logic [PC_W-1:0] trig_pc,
    input  logic [AW-1:0]   rd_addr,
    output logic [EW-1:0]   rd_data,
    output logic [1:0]      state,
    output logic [AW:0]     count,
    output logic [AW-1:0]   trig_index
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [AW:0]   C_COUNT_MAX = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] C_PTR_LAST  = AW'(DEPTH - 1);
    localparam logic [AW-1:0] C_POST_INIT = AW'(POST_TRIG);

    state_t          cur_state;
    state_t          nxt_state;
    logic [AW-1:0]   wr_ptr;
    logic            wrapped;
    logic [AW-1:0]   post_cnt;
    logic [AW-1:0]   post_cnt_nxt;
    logic [AW-1:0]   trig_pos;
    logic [EW-1:0]   mem [DEPTH];

    logic            capturing;
    logic            wr_en;
    logic            trig_hit;
    logic [EW-1:0]   entry;
    logic [AW-1:0]   oldest;
    logic [AW-1:0]   rd_phys;

`ifdef TRACE_FLAGS_EN
    assign entry = {sample_flags, sample_pc, sample_instr};
`else
    assign entry = {sample_pc, sample_instr};
    logic unused_flags;
    assign unused_flags = ^sample_flags;
`endif

    // A sample coincident with arm is dropped: arm restarts capture from empty.
    assign capturing = (cur_state == ARMED) || (cur_state == POST);
    assign wr_en     = sample_valid && !arm && capturing;
    assign trig_hit  = wr_en && (cur_state == ARMED) && trig_en && (sample_pc == trig_pc);

    // Until the first wrap the oldest entry is slot 0; afterwards it is the
    // slot about to be overwritten.
    assign oldest     = wrapped ? wr_ptr : '0;
    assign rd_phys    = oldest + rd_addr;
    assign trig_index = trig_pos - oldest;
    assign state      = cur_state;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_state <= IDLE;
            post_cnt  <= '0;
        end else begin
            cur_state <= nxt_state;
            post_cnt  <= post_cnt_nxt;
        end
    end

    // Next-state logic: arm overrides everything, trigger only in ARMED.
    always_comb begin
        nxt_state    = cur_state;
        post_cnt_nxt = post_cnt;
        if (arm) begin
            nxt_state = ARMED;
        end else begin
            case (cur_state)
                ARMED: begin
                    if (trig_hit) begin
                        if (POST_TRIG == 0) begin
                            nxt_state = DONE;
                        end else begin
                            nxt_state    = POST;
                            post_cnt_nxt = C_POST_INIT;
                        end
                    end
                end
                POST: begin
                    if (wr_en) begin
                        post_cnt_nxt = post_cnt - 1'b1;
                        if (post_cnt == AW'(1)) begin
                            nxt_state = DONE;
                        end
                    end
                end
                default: begin
                    nxt_state = cur_state;
                end
            endcase
        end
    end

    // Write pointer, fill count, wrap flag and trigger position.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            count    <= '0;
            wrapped  <= 1'b0;
            trig_pos <= '0;
        end else if (arm) begin
            wr_ptr  <= '0;
            count   <= '0;
            wrapped <= 1'b0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (count != C_COUNT_MAX) begin
                count <= count + 1'b1;
            end
            if (wr_ptr == C_PTR_LAST) begin
                wrapped <= 1'b1;
            end
            if (trig_hit) begin
                trig_pos <= wr_ptr;
            end
        end
    end

    // Trace RAM write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= entry;
        end
    end

    // Registered read port, logical index translated to physical slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_phys];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_z8_trace_buffer.sv
// ============================================================================
// Module   : tb_z8_trace_buffer
// Brief    : Self-checking bench for z8_trace_buffer. Two instances share the
//            stimulus: a default one (DEPTH 64, POST_TRIG 16) and a minimum one
//            (DEPTH 4, POST_TRIG 0). A history-based model predicts outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_z8_trace_buffer;

    localparam int PC_W = 16;
    localparam int D0   = 64;
    localparam int P0   = 16;
    localparam int D1   = 4;
    localparam int P1   = 0;
`ifdef TRACE_FLAGS_EN
    localparam int EW   = PC_W + 16;
`else
    localparam int EW   = PC_W + 8;
`endif

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            sample_valid = 1'b0;
    logic [PC_W-1:0] sample_pc = '0;
    logic [7:0]      sample_instr = '0;
    logic [7:0]      sample_flags = '0;
    logic            arm = 1'b0;
    logic            trig_en = 1'b0;
    logic [PC_W-1:0] trig_pc = '0;
    logic [5:0]      rd_addr = '0;

    logic [EW-1:0]   rd_data0, rd_data1;
    logic [1:0]      state0, state1;
    logic [6:0]      count0;
    logic [2:0]      count1;
    logic [5:0]      trig_index0;
    logic [1:0]      trig_index1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    z8_trace_buffer #(.DEPTH(D0), .PC_W(PC_W), .POST_TRIG(P0)) dut0 (
        .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid),
        .sample_pc(sample_pc), .sample_instr(sample_instr), .sample_flags(sample_flags),
        .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc), .rd_addr(rd_addr),
        .rd_data(rd_data0), .state(state0), .count(count0), .trig_index(trig_index0)
    );

    z8_trace_buffer #(.DEPTH(D1), .PC_W(PC_W), .POST_TRIG(P1)) dut1 (
        .clk(clk), .reset_n(reset_n), .sample_valid(sample_valid),
        .sample_pc(sample_pc), .sample_instr(sample_instr), .sample_flags(sample_flags),
        .arm(arm), .trig_en(trig_en), .trig_pc(trig_pc), .rd_addr(rd_addr[1:0]),
        .rd_data(rd_data1), .state(state1), .count(count1), .trig_index(trig_index1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model: history of samples since arm -------
    int            m_state [2];
    int            m_total [2];   // samples stored since last arm
    int            m_trig  [2];   // absolute sample number of trigger
    int            m_post  [2];
    logic [EW-1:0] hist    [2][256];
    logic [EW-1:0] m_rd    [2];
    bit            m_rd_ok [2];

    function automatic int dep(input int k);
        return (k == 0) ? D0 : D1;
    endfunction

    function automatic int post_n(input int k);
        return (k == 0) ? P0 : P1;
    endfunction

    function automatic int m_count(input int k);
        return (m_total[k] < dep(k)) ? m_total[k] : dep(k);
    endfunction

    function automatic int m_oldest(input int k);
        return (m_total[k] > dep(k)) ? m_total[k] - dep(k) : 0;
    endfunction

    function automatic logic [EW-1:0] cur_entry();
`ifdef TRACE_FLAGS_EN
        return {sample_flags, sample_pc, sample_instr};
`else
        return {sample_pc, sample_instr};
`endif
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) begin
                m_state[k] = 0; m_total[k] = 0; m_trig[k] = 0; m_post[k] = 0;
                m_rd[k] = '0; m_rd_ok[k] = 1'b1;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                int ra;
                ra = int'(rd_addr) % dep(k);
                m_rd_ok[k] = (ra < m_count(k));
                if (m_rd_ok[k]) m_rd[k] = hist[k][(m_oldest(k) + ra) % 256];
                if (arm) begin
                    m_state[k] = 1;
                    m_total[k] = 0;
                end else if ((m_state[k] == 1 || m_state[k] == 2) && sample_valid) begin
                    hist[k][m_total[k] % 256] = cur_entry();
                    if (m_state[k] == 1 && trig_en && sample_pc == trig_pc) begin
                        m_trig[k] = m_total[k];
                        if (post_n(k) == 0) m_state[k] = 3;
                        else begin m_state[k] = 2; m_post[k] = post_n(k); end
                    end else if (m_state[k] == 2) begin
                        m_post[k]--;
                        if (m_post[k] == 0) m_state[k] = 3;
                    end
                    m_total[k]++;
                end
            end
        end
    end

    // Compare both instances against the model every cycle.
    always @(negedge clk) begin
        chk("state0", 64'(state0), 64'(m_state[0]));
        chk("count0", 64'(count0), 64'(m_count(0)));
        chk("state1", 64'(state1), 64'(m_state[1]));
        chk("count1", 64'(count1), 64'(m_count(1)));
        if (m_state[0] == 3 || !reset_n)
            chk("trig_index0", 64'(trig_index0), 64'(m_trig[0] - m_oldest(0)));
        if (m_state[1] == 3 || !reset_n)
            chk("trig_index1", 64'(trig_index1), 64'(m_trig[1] - m_oldest(1)));
        if (m_rd_ok[0]) chk("rd_data0", 64'(rd_data0), 64'(m_rd[0]));
        if (m_rd_ok[1]) chk("rd_data1", 64'(rd_data1), 64'(m_rd[1]));
    end

    // ---------------- stimulus ---------------------------------------------
    task automatic cyc(input bit a, input bit v, input logic [PC_W-1:0] pc, input logic [7:0] fl);
        arm          = a;
        sample_valid = v;
        sample_pc    = pc;
        sample_instr = pc[7:0] ^ 8'h5A;
        sample_flags = fl;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #2;
        chk("reset_state", 64'(state0), 64'd0);
        chk("reset_count", 64'(count0), 64'd0);
        chk("reset_rd_data", 64'(rd_data0), 64'd0);
        chk("reset_trig_index", 64'(trig_index0), 64'd0);
        reset_n = 1'b1;
        cyc(0, 1, 16'h0B00, 8'h00);
        chk("idle_ignores", 64'(count0), 64'd0);

        // Capture without trigger, then read back a middle entry.
        trig_en = 1'b0;
        cyc(1, 0, 16'h0000, 8'h00);
        for (int i = 0; i < 5; i++) cyc(0, 1, 16'h0C00 + 16'(i), 8'h11);
        chk("t2_state", 64'(state0), 64'd1);
        chk("t2_count", 64'(count0), 64'd5);
        rd_addr = 6'd2;
        cyc(0, 0, 16'h0000, 8'h00);
        chk("t2_rd_pc", 64'(rd_data0[PC_W+7:8]), 64'h0C02);

        // Overrun then trigger with POST_TRIG further samples.
        trig_en = 1'b1;
        trig_pc = 16'h0C50;
        cyc(1, 0, 16'h0000, 8'h00);
        for (int i = 0; i < 100; i++) cyc(0, 1, 16'h0C00 + 16'(i), 8'h22);
        chk("t3_state", 64'(state0), 64'd3);
        chk("t3_count", 64'(count0), 64'd64);
        chk("t3_trig_index", 64'(trig_index0), 64'd47);
        rd_addr = 6'd0;
        cyc(0, 0, 16'h0000, 8'h00);
        chk("t3_oldest_pc", 64'(rd_data0[PC_W+7:8]), 64'h0C21);

        // POST_TRIG=0 instance: trigger on third sample finishes immediately.
        trig_pc = 16'h0D02;
        cyc(1, 0, 16'h0000, 8'h00);
        cyc(0, 1, 16'h0D00, 8'h00);
        cyc(0, 1, 16'h0D01, 8'h00);
        cyc(0, 1, 16'h0D02, 8'hA5);
        chk("t4_state1", 64'(state1), 64'd3);
        chk("t4_count1", 64'(count1), 64'd3);
        chk("t4_trig_index1", 64'(trig_index1), 64'd2);
        rd_addr = 6'd2;
        cyc(0, 0, 16'h0000, 8'h00);
        chk("t4_rd_pc1", 64'(rd_data1[PC_W+7:8]), 64'h0D02);
`ifdef TRACE_FLAGS_EN
        chk("t6_flags", 64'(rd_data1[PC_W+15:PC_W+8]), 64'hA5);
`endif

        // Arm while in POST with a coincident sample.
        trig_pc = 16'h0E01;
        cyc(1, 0, 16'h0000, 8'h00);
        cyc(0, 1, 16'h0E00, 8'h00);
        cyc(0, 1, 16'h0E01, 8'h00);
        cyc(0, 1, 16'h0E02, 8'h00);
        chk("t5_in_post", 64'(state0), 64'd2);
        cyc(1, 1, 16'h0E03, 8'h00);
        chk("t5_state", 64'(state0), 64'd1);
        chk("t5_count", 64'(count0), 64'd0);

        // Asynchronous reset in the middle of POST.
        cyc(0, 1, 16'h0E00, 8'h00);
        cyc(0, 1, 16'h0E01, 8'h00);
        chk("t1_in_post", 64'(state0), 64'd2);
        #1 reset_n = 1'b0;
        #1;
        chk("t1_async_state", 64'(state0), 64'd0);
        chk("t1_async_count", 64'(count0), 64'd0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) cyc(0, 1, 16'h0E01, 8'h00);
        chk("t1_after_state", 64'(state0), 64'd0);
        chk("t1_after_count", 64'(count0), 64'd0);

        // Randomised phase: small PC range so triggers occur regularly.
        for (int n = 0; n < 3000; n++) begin
            bit a;
            a = ($urandom_range(0, 63) == 0);
            if (a) trig_pc = 16'h0F00 + 16'($urandom_range(0, 63));
            if ($urandom_range(0, 15) == 0) trig_en = 1'($urandom_range(0, 3) != 0);
            rd_addr = 6'($urandom);
            cyc(a, 1'($urandom_range(0, 1)), 16'h0F00 + 16'($urandom_range(0, 63)), 8'($urandom));
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
